bayer_line_sched: RTL and testbench

Line-buffer sequencer for the RAW10→RGB565 demosaic stage between the MIPI RAW10 depacker and the DDR3 write path. It counts depacker beats into rows and frames and drives write/read enables for the single-line FIFO. It supplies the Bayer row phase and first-row flag to the demosaic datapath, and an output-valid strobe aligned to that datapath. At frame end it drains the stale last line so each frame starts with an empty FIFO, and it flags malformed frames.

---
 rtl/bayer_line_sched_if.sv | 29 ++
 rtl/bayer_line_sched.sv | 163 ++++++++++++++++
 tb/tb_bayer_line_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bayer_line_sched_if.sv
// Beat, FIFO-control and demosaic-sideband signals of the Bayer line sequencer.
interface bayer_line_sched_if;
  logic        I_Mipi_Unpacket_V_sync;
  logic        I_Mipi_raw10_depacker_Vaild;
  logic        I_Fifo_Empty;
  logic        I_Fifo_Full;
  logic        O_Fifo_Wr_EN;
  logic        O_Fifo_Rd_EN;
  logic        O_Fifo_Rst;
  logic        O_Row_Parity;
  logic        O_First_Row;
  logic        O_RGB_Vaild;
  logic [12:0] O_Row_Cnt;
  logic [12:0] O_Col_Cnt;
  logic        O_Frame_Done;
  logic        O_Err_Frame;

  modport slave (
    input  I_Mipi_Unpacket_V_sync, I_Mipi_raw10_depacker_Vaild, I_Fifo_Empty, I_Fifo_Full,
    output O_Fifo_Wr_EN, O_Fifo_Rd_EN, O_Fifo_Rst, O_Row_Parity, O_First_Row, O_RGB_Vaild,
           O_Row_Cnt, O_Col_Cnt, O_Frame_Done, O_Err_Frame
  );

  modport master (
    output I_Mipi_Unpacket_V_sync, I_Mipi_raw10_depacker_Vaild, I_Fifo_Empty, I_Fifo_Full,
    input  O_Fifo_Wr_EN, O_Fifo_Rd_EN, O_Fifo_Rst, O_Row_Parity, O_First_Row, O_RGB_Vaild,
           O_Row_Cnt, O_Col_Cnt, O_Frame_Done, O_Err_Frame
  );
endinterface

// File: rtl/bayer_line_sched.sv
// Line-buffer sequencer for the RAW10->RGB565 demosaic stage.
// Define BAYER_SCHED_DRAIN_EN to drain the stale last line through DRAIN at frame end.
module bayer_line_sched #(
  parameter int IMAGE_WIDTH  = 1920,
  parameter int IMAGE_HEIGHT = 1080,
  parameter int PIXEL_NUM    = 4,
  parameter int COL_MAX      = IMAGE_WIDTH / PIXEL_NUM,
  parameter int OUT_LAT      = 2
) (
  input  logic              I_CLK,
  input  logic              I_Rst,
  bayer_line_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ROW0, STREAM, DRAIN} state_t;

  localparam logic [12:0] COL_LAST = 13'(COL_MAX - 1);
  localparam logic [12:0] ROW_LAST = 13'(IMAGE_HEIGHT - 1);

`ifdef BAYER_SCHED_DRAIN_EN
  localparam state_t FRAME_END = DRAIN;
`else
  localparam state_t FRAME_END = IDLE;
`endif

  state_t             state;
  state_t             state_nxt;
  logic [12:0]        row_cnt;
  logic [12:0]        col_cnt;
  logic               parity;
  logic [OUT_LAT-1:0] rgb_pipe;
  logic               err_q;
  logic               fifo_rst_q;
  logic               done_q;

  logic vsync;
  logic valid;
  logic empty;
  logic full;

  assign vsync = bus.I_Mipi_Unpacket_V_sync;
  assign valid = bus.I_Mipi_raw10_depacker_Vaild;
  assign empty = bus.I_Fifo_Empty;
  assign full  = bus.I_Fifo_Full;

  logic writing;
  logic accept;
  logic col_wrap;
  logic last_wrap;
  logic rd_req;
  logic drain_rd;
  logic drain_last;
  logic end_pulse;
  logic clean_restart;
  logic restart_err;
  logic status_err;
  logic drain_beat_err;

  assign writing   = (state == ROW0) || (state == STREAM);
  assign accept    = valid && !vsync && writing;
  assign col_wrap  = accept && (col_cnt == COL_LAST);
  assign last_wrap = col_wrap && (row_cnt == ROW_LAST);
  assign rd_req    = accept && (state == STREAM);

`ifdef BAYER_SCHED_DRAIN_EN
  logic [12:0] drain_cnt;

  assign drain_rd   = (state == DRAIN) && !empty;
  assign drain_last = drain_rd && (drain_cnt == COL_LAST);
  assign end_pulse  = 1'b0;

  always_ff @(posedge I_CLK) begin
    if (I_Rst) begin
      drain_cnt <= '0;
    end else if ((state != DRAIN) || drain_last) begin
      drain_cnt <= '0;
    end else if (drain_rd) begin
      drain_cnt <= drain_cnt + 13'd1;
    end
  end
`else
  assign drain_rd   = 1'b0;
  assign drain_last = 1'b0;
  // Without a drain the FIFO is simply cleared once the last line is written.
  assign end_pulse  = last_wrap;
`endif

  assign clean_restart  = (state == IDLE) || drain_last || ((state == ROW0) && (col_cnt == '0));
  assign restart_err    = vsync && !clean_restart;
  assign status_err     = (accept && full) || (rd_req && empty);
  assign drain_beat_err = valid && !vsync && (state == DRAIN);

  assign bus.O_Fifo_Wr_EN = accept && !full;
  assign bus.O_Fifo_Rd_EN = (rd_req && !empty) || drain_rd;
  assign bus.O_Fifo_Rst   = fifo_rst_q;
  assign bus.O_Row_Parity = parity;
  assign bus.O_First_Row  = (state == ROW0);
  assign bus.O_RGB_Vaild  = rgb_pipe[OUT_LAT-1];
  assign bus.O_Row_Cnt    = row_cnt;
  assign bus.O_Col_Cnt    = col_cnt;
  assign bus.O_Frame_Done = done_q;
  assign bus.O_Err_Frame  = err_q;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:         state_nxt = IDLE;
      ROW0, STREAM: begin
        if (last_wrap) begin
          state_nxt = FRAME_END;
        end else if (col_wrap) begin
          state_nxt = STREAM;
        end
      end
      DRAIN:        if (drain_last) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
    if (vsync) begin
      state_nxt = ROW0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge I_CLK) begin
    if (I_Rst) begin
      state      <= IDLE;
      row_cnt    <= '0;
      col_cnt    <= '0;
      parity     <= 1'b0;
      rgb_pipe   <= '0;
      err_q      <= 1'b0;
      fifo_rst_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      rgb_pipe   <= (rgb_pipe << 1) | OUT_LAT'(accept);
      err_q      <= restart_err || status_err || drain_beat_err;
      fifo_rst_q <= restart_err || end_pulse;
      done_q     <= drain_last || end_pulse;
      if (vsync) begin
        row_cnt <= '0;
        col_cnt <= '0;
        parity  <= 1'b0;
      end else if (accept) begin
        if (col_wrap) begin
          col_cnt <= '0;
          // After the last line the indices point at row 0 of the next frame.
          if (last_wrap) begin
            row_cnt <= '0;
            parity  <= 1'b0;
          end else begin
            row_cnt <= row_cnt + 13'd1;
            parity  <= ~parity;
          end
        end else begin
          col_cnt <= col_cnt + 13'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bayer_line_sched.sv
// Self-checking bench for bayer_line_sched against a beat-counting frame model.
module tb_bayer_line_sched;

  localparam int W     = 16;
  localparam int H     = 3;
  localparam int PN    = 4;
  localparam int CM    = W / PN;
  localparam int LAT   = 2;
  localparam int TOTAL = CM * H;
`ifdef BAYER_SCHED_DRAIN_EN
  localparam int DR    = CM;
  localparam int ENDRST = 0;
`else
  localparam int DR    = 0;
  localparam int ENDRST = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bayer_line_sched_if bus();

  bayer_line_sched #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .PIXEL_NUM   (PN),
    .COL_MAX     (CM),
    .OUT_LAT     (LAT)
  ) dut (
    .I_CLK(clk),
    .I_Rst(rst),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic        frst;
    logic        par;
    logic        first;
    logic        rgb;
    logic        done;
    logic        err;
    logic [12:0] row;
    logic [12:0] col;
  } obs_t;

  obs_t got;
  obs_t exp;
  int   vectors;
  int   miscompares;
  int   cyc;

  // Frame model: a frame is a count of accepted beats, then (optionally) CM drain reads.
  bit           in_frame;
  bit           draining;
  int           beats;
  int           drain_reads;
  bit           p_err;
  bit           p_rst;
  bit           p_done;
  bit [LAT-1:0] hist;

  int n_wr, n_rd, n_rgb, n_done, n_err, n_frst;

  function automatic string fmt(obs_t o);
    return $sformatf("wr%0b rd%0b frst%0b par%0b first%0b rgb%0b done%0b err%0b row%0d col%0d",
                     o.wr, o.rd, o.frst, o.par, o.first, o.rgb, o.done, o.err, o.row, o.col);
  endfunction

  task automatic model_reset();
    in_frame    = 0;
    draining    = 0;
    beats       = 0;
    drain_reads = 0;
    p_err       = 0;
    p_rst       = 0;
    p_done      = 0;
    hist        = '0;
  endtask

  task automatic clear_tally();
    n_wr = 0; n_rd = 0; n_rgb = 0; n_done = 0; n_err = 0; n_frst = 0;
  endtask

  // One clock: drive inputs, sample the DUT, predict its outputs, then advance the model.
  task automatic tick(input bit v, input bit vs, input bit em, input bit fu);
    bit accept, rd_req, dr, final_rd, clean;
    @(negedge clk);
    bus.I_Mipi_raw10_depacker_Vaild = v;
    bus.I_Mipi_Unpacket_V_sync      = vs;
    bus.I_Fifo_Empty                = em;
    bus.I_Fifo_Full                 = fu;
    #1;
    cyc++;
    got = '{wr: bus.O_Fifo_Wr_EN, rd: bus.O_Fifo_Rd_EN, frst: bus.O_Fifo_Rst,
            par: bus.O_Row_Parity, first: bus.O_First_Row, rgb: bus.O_RGB_Vaild,
            done: bus.O_Frame_Done, err: bus.O_Err_Frame,
            row: bus.O_Row_Cnt, col: bus.O_Col_Cnt};
    n_wr   += int'(got.wr);
    n_rd   += int'(got.rd);
    n_rgb  += int'(got.rgb);
    n_done += int'(got.done);
    n_err  += int'(got.err);
    n_frst += int'(got.frst);

    accept = in_frame && !draining && v && !vs;
    rd_req = accept && (beats >= CM);
`ifdef BAYER_SCHED_DRAIN_EN
    dr = draining && !em;
`else
    dr = 0;
`endif
    exp       = '0;
    exp.row   = 13'(beats / CM);
    exp.col   = 13'(beats % CM);
    exp.par   = ((beats / CM) % 2) != 0;
    exp.first = in_frame && !draining && (beats < CM);
    exp.wr    = accept && !fu;
    exp.rd    = (rd_req && !em) || dr;
    exp.rgb   = hist[LAT-1];
    exp.done  = p_done;
    exp.err   = p_err;
    exp.frst  = p_rst;

    final_rd = dr && (drain_reads == CM - 1);
    clean    = !in_frame || (!draining && beats == 0) || final_rd;
    hist     = {hist[LAT-2:0], accept};
    p_err    = (accept && fu) || (rd_req && em) || (draining && v && !vs);
    p_rst    = 0;
    p_done   = 0;
    if (dr) drain_reads++;
    if (final_rd) begin
      draining = 0;
      in_frame = 0;
      p_done   = 1;
    end
    if (accept) begin
      beats++;
      if (beats == TOTAL) begin
        beats = 0;
`ifdef BAYER_SCHED_DRAIN_EN
        draining    = 1;
        drain_reads = 0;
`else
        in_frame = 0;
        p_done   = 1;
        p_rst    = 1;
`endif
      end
    end
    if (vs) begin
      if (!clean) begin
        p_err = 1;
        p_rst = 1;
      end
      in_frame    = 1;
      draining    = 0;
      beats       = 0;
      drain_reads = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.I_Mipi_Unpacket_V_sync      = 1'b0;
    bus.I_Mipi_raw10_depacker_Vaild = 1'b0;
    bus.I_Fifo_Empty                = 1'b0;
    bus.I_Fifo_Full                 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    clear_tally();
    // Beats in IDLE must be ignored.
    for (int i = 0; i < 6; i++) begin
      tick(i >= 1, 0, 0, 0);
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d got %s want %s", cyc, fmt(got), fmt(exp));
      end
      vectors++;
    end
    if ({n_wr, n_rd, n_rgb, n_err} !== {32'd0, 32'd0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL idle_strobes got wr%0d rd%0d rgb%0d err%0d want all 0", n_wr, n_rd, n_rgb, n_err);
    end
    vectors++;
  endtask

  task automatic test_nominal();
    clear_tally();
    for (int i = 0; i < 1 + TOTAL + 10; i++) begin
      tick(i >= 1 && i <= TOTAL, i == 0, 0, 0);
      if (got !== exp) begin
        miscompares++;
        $display("FAIL nominal cyc=%0d got %s want %s", cyc, fmt(got), fmt(exp));
      end
      vectors++;
    end
    if ({n_wr, n_rd, n_rgb, n_done, n_err, n_frst} !==
        {32'(TOTAL), 32'(2 * CM + DR), 32'(TOTAL), 32'd1, 32'd0, 32'(ENDRST)}) begin
      miscompares++;
      $display("FAIL nominal_counts got wr%0d rd%0d rgb%0d done%0d err%0d frst%0d want wr%0d rd%0d rgb%0d done1 err0 frst%0d",
               n_wr, n_rd, n_rgb, n_done, n_err, n_frst, TOTAL, 2 * CM + DR, TOTAL, ENDRST);
    end
    vectors++;
  endtask

  task automatic test_gapped();
    int sent = 0;
    clear_tally();
    for (int i = 0; i < 1 + 3 * TOTAL + 10; i++) begin
      bit v = (i >= 1) && ((i - 1) % 3 == 0) && (sent < TOTAL);
      if (v) sent++;
      tick(v, i == 0, 0, 0);
      if (got !== exp) begin
        miscompares++;
        $display("FAIL gapped cyc=%0d got %s want %s", cyc, fmt(got), fmt(exp));
      end
      vectors++;
    end
    if ({n_wr, n_rd, n_rgb, n_done} !== {32'(TOTAL), 32'(2 * CM + DR), 32'(TOTAL), 32'd1}) begin
      miscompares++;
      $display("FAIL gapped_counts got wr%0d rd%0d rgb%0d done%0d want wr%0d rd%0d rgb%0d done1",
               n_wr, n_rd, n_rgb, n_done, TOTAL, 2 * CM + DR, TOTAL);
    end
    vectors++;
  endtask

  task automatic test_early_vsync();
    clear_tally();
    for (int i = 0; i < 1 + 6 + 1 + TOTAL + 10; i++) begin
      bit vs = (i == 0) || (i == 7);
      bit v  = !vs && (i <= 7 + TOTAL);
      tick(v, vs, 0, 0);
      if (got !== exp) begin
        miscompares++;
        $display("FAIL early_vsync cyc=%0d got %s want %s", cyc, fmt(got), fmt(exp));
      end
      vectors++;
    end
    if ({n_err, n_frst, n_done, n_wr} !== {32'd1, 32'(1 + ENDRST), 32'd1, 32'(6 + TOTAL)}) begin
      miscompares++;
      $display("FAIL early_vsync_counts got err%0d frst%0d done%0d wr%0d want err1 frst%0d done1 wr%0d",
               n_err, n_frst, n_done, n_wr, 1 + ENDRST, 6 + TOTAL);
    end
    vectors++;
  endtask

`ifdef BAYER_SCHED_DRAIN_EN
  task automatic test_drain_empty();
    int last_beat = 0;
    int done_at   = 0;
    clear_tally();
    for (int i = 0; i < 1 + TOTAL + 16; i++) begin
      int  j  = i - TOTAL;
      bit  em = (j >= 3) && (j <= 7);
      tick(i >= 1 && i <= TOTAL, i == 0, em, 0);
      if (i == TOTAL) last_beat = cyc;
      if (got.done === 1'b1 && done_at == 0) done_at = cyc;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL drain_empty cyc=%0d got %s want %s", cyc, fmt(got), fmt(exp));
      end
      vectors++;
    end
    if ({n_rd, n_done, done_at - last_beat} !== {32'(2 * CM + CM), 32'd1, 32'd10}) begin
      miscompares++;
      $display("FAIL drain_empty_timing got rd%0d done%0d delay%0d want rd%0d done1 delay10",
               n_rd, n_done, done_at - last_beat, 3 * CM);
    end
    vectors++;
  endtask

  task automatic test_drain_beat();
    clear_tally();
    for (int i = 0; i < 1 + TOTAL + 10; i++) begin
      tick((i >= 1 && i <= TOTAL) || (i == TOTAL + 2), i == 0, 0, 0);
      if (got !== exp) begin
        miscompares++;
        $display("FAIL drain_beat cyc=%0d got %s want %s", cyc, fmt(got), fmt(exp));
      end
      vectors++;
    end
    if ({n_err, n_wr, n_rd, n_done} !== {32'd1, 32'(TOTAL), 32'(3 * CM), 32'd1}) begin
      miscompares++;
      $display("FAIL drain_beat_counts got err%0d wr%0d rd%0d done%0d want err1 wr%0d rd%0d done1",
               n_err, n_wr, n_rd, n_done, TOTAL, 3 * CM);
    end
    vectors++;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(1, 0) == 1, $urandom_range(39, 0) == 0,
           $urandom_range(7, 0) == 0, $urandom_range(9, 0) == 0);
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random cyc=%0d got %s want %s", cyc, fmt(got), fmt(exp));
      end
      vectors++;
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) begin
      tick(i >= 1, i == 0, 0, 0);
      if (got !== exp) begin
        miscompares++;
        $display("FAIL mid_reset_pre cyc=%0d got %s want %s", cyc, fmt(got), fmt(exp));
      end
      vectors++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0);
      if (got !== exp) begin
        miscompares++;
        $display("FAIL mid_reset cyc=%0d got %s want %s", cyc, fmt(got), fmt(exp));
      end
      vectors++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    test_reset();
    test_nominal();
    test_gapped();
    test_early_vsync();
`ifdef BAYER_SCHED_DRAIN_EN
    test_drain_empty();
    test_drain_beat();
`endif
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
